// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and fetch counter.
// Optional macro FETCH_ALIGN_CHECK_EN adds redirect alignment / IMEM range checking with a sticky HALT.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_BYTES = 128
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    input  logic [31:0] im_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] fetch_count,
    output logic        fetch_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT,
        ST_RUN
`ifdef FETCH_ALIGN_CHECK_EN
        , ST_HALT
`endif
    } state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic              id_valid_q, id_valid_d;
    logic [XLEN-1:0]   id_instr_q, id_instr_d;
    logic [XLEN-1:0]   id_pc_q, id_pc_d;
    logic [XLEN-1:0]   id_pc_plus4_q, id_pc_plus4_d;
    logic [XLEN-1:0]   fetch_count_q, fetch_count_d;
    logic [XLEN-1:0]   pc_plus4;
    logic [XLEN-1:0]   redirect_tgt;
    logic              advance;

    assign pc_plus4 = pc_q + XLEN'(4);
    assign advance  = !redirect_valid && !flush && !stall;

`ifdef FETCH_ALIGN_CHECK_EN
    logic fetch_err_q, fetch_err_d;
    logic align_err;
    logic range_err;

    assign redirect_tgt = redirect_pc;
    assign align_err    = redirect_valid && (redirect_pc[1:0] != 2'b00);
    assign range_err    = advance && (pc_q >= XLEN'(IMEM_BYTES));
    assign fetch_err    = fetch_err_q;
`else
    logic unused_cfg;

    // Without checking, low target bits are simply dropped to keep the PC word aligned.
    assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
    assign unused_cfg   = ^{redirect_pc[1:0], XLEN'(IMEM_BYTES)};
    assign fetch_err    = 1'b0;
`endif

    // Next-state and datapath update, priority redirect > flush > stall > advance.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        id_valid_d    = id_valid_q;
        id_instr_d    = id_instr_q;
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        fetch_count_d = fetch_count_q;
`ifdef FETCH_ALIGN_CHECK_EN
        fetch_err_d   = fetch_err_q;
`endif
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
`ifdef FETCH_ALIGN_CHECK_EN
                if (align_err || range_err) begin
                    state_d     = ST_HALT;
                    fetch_err_d = 1'b1;
                    id_valid_d  = 1'b0;
                end else
`endif
                if (redirect_valid) begin
                    pc_d       = redirect_tgt;
                    id_valid_d = 1'b0;
                end else if (flush) begin
                    id_valid_d = 1'b0;
                    if (!stall) begin
                        pc_d = pc_plus4;
                    end
                end else if (!stall) begin
                    id_instr_d    = im_instr;
                    id_pc_d       = pc_q;
                    id_pc_plus4_d = pc_plus4;
                    id_valid_d    = 1'b1;
                    pc_d          = pc_plus4;
                    if (fetch_count_q != '1) begin
                        fetch_count_d = fetch_count_q + XLEN'(1);
                    end
                end
            end
`ifdef FETCH_ALIGN_CHECK_EN
            ST_HALT: begin
                id_valid_d = 1'b0;
            end
`endif
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_BOOT;
            pc_q          <= RESET_PC;
            id_valid_q    <= 1'b0;
            id_instr_q    <= '0;
            id_pc_q       <= '0;
            id_pc_plus4_q <= '0;
            fetch_count_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            id_valid_q    <= id_valid_d;
            id_instr_q    <= id_instr_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            fetch_count_q <= fetch_count_d;
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err_q <= 1'b0;
        end else begin
            fetch_err_q <= fetch_err_d;
        end
    end
`endif

    assign pc_out      = pc_q;
    assign id_valid    = id_valid_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_pc_plus4 = id_pc_plus4_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a stimulus process predicts each cycle's outputs
// from an abstract PC/IF-ID model, a monitor process compares after every rising edge.
module tb_fetch_unit;

    localparam int unsigned IMEM = 128;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] pc_out, im_instr;
    logic        stall = 1'b0, flush = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_valid, fetch_err;
    logic [31:0] id_instr, id_pc, id_pc_plus4, fetch_count;

    logic [31:0] pc_out_w, im_instr_w, id_instr_w, id_pc_w, id_pc_plus4_w, fetch_count_w;
    logic        id_valid_w, fetch_err_w;
    logic        zero_b = 1'b0;
    logic [31:0] zero_w = 32'h0;

    logic [31:0] mem [64];

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] pc, instr, idpc, idpc4, cnt;
        logic        valid, err;
    } snap_t;
    snap_t sb[$];

    // Abstract model state
    bit          m_booted, m_halt, m_valid, m_err;
    logic [31:0] m_pc, m_instr, m_idpc, m_idpc4, m_cnt;

    always #5 clk = ~clk;

    assign im_instr   = mem[pc_out[7:2]];
    assign im_instr_w = mem[pc_out_w[7:2]];

    fetch_unit #(.RESET_PC(32'h0), .IMEM_BYTES(IMEM)) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .im_instr(im_instr),
        .stall(stall), .flush(flush), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4),
        .fetch_count(fetch_count), .fetch_err(fetch_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .IMEM_BYTES(IMEM)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out_w), .im_instr(im_instr_w),
        .stall(zero_b), .flush(zero_b), .redirect_valid(zero_b), .redirect_pc(zero_w),
        .id_valid(id_valid_w), .id_instr(id_instr_w), .id_pc(id_pc_w), .id_pc_plus4(id_pc_plus4_w),
        .fetch_count(fetch_count_w), .fetch_err(fetch_err_w)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_booted = 0; m_halt = 0; m_valid = 0; m_err = 0;
        m_pc = 32'h0; m_instr = 0; m_idpc = 0; m_idpc4 = 0; m_cnt = 0;
    endtask

    // Drive one cycle of inputs at the falling edge and queue the post-edge expectation.
    task automatic cycle(input bit s, input bit f, input bit r, input logic [31:0] rpc);
        snap_t e;
        bit adv;
        @(negedge clk);
        stall = s; flush = f; redirect_valid = r; redirect_pc = rpc;
        adv = !r && !f && !s;
        if (!m_booted) begin
            m_booted = 1;
        end else if (m_halt) begin
            m_valid = 0;
        end else begin
`ifdef FETCH_ALIGN_CHECK_EN
            if ((r && (rpc % 4 != 0)) || (adv && m_pc >= IMEM)) begin
                m_halt = 1; m_err = 1; m_valid = 0;
            end else
`endif
            if (r) begin
                m_pc = rpc - (rpc % 4);
                m_valid = 0;
            end else if (f) begin
                m_valid = 0;
                if (!s) m_pc = m_pc + 4;
            end else if (adv) begin
                m_instr = mem[m_pc[7:2]];
                m_idpc  = m_pc;
                m_idpc4 = m_pc + 4;
                m_valid = 1;
                m_pc    = m_pc + 4;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end
        e.pc = m_pc; e.instr = m_instr; e.idpc = m_idpc; e.idpc4 = m_idpc4;
        e.cnt = m_cnt; e.valid = m_valid; e.err = m_err;
        sb.push_back(e);
    endtask

    // Assert reset between edges with whatever inputs are live, then check without a clock edge.
    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_pc", pc_out, 32'h0);
        chk("rst_valid", 32'(id_valid), 32'h0);
        chk("rst_instr", id_instr, 32'h0);
        chk("rst_idpc", id_pc, 32'h0);
        chk("rst_idpc4", id_pc_plus4, 32'h0);
        chk("rst_count", fetch_count, 32'h0);
        chk("rst_err", 32'(fetch_err), 32'h0);
        stall = 0; flush = 0; redirect_valid = 0; redirect_pc = 0;
        model_reset();
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // Monitor: every out-of-reset edge must have exactly one queued expectation.
    initial begin
        snap_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (sb.size() == 0) begin
                    chk("sb_underflow", 32'h1, 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("pc_out", pc_out, e.pc);
                    chk("id_valid", 32'(id_valid), 32'(e.valid));
                    chk("id_pc", id_pc, e.idpc);
                    chk("id_pc_plus4", id_pc_plus4, e.idpc4);
                    chk("fetch_count", fetch_count, e.cnt);
                    chk("fetch_err", 32'(fetch_err), 32'(e.err));
                    if (e.valid) chk("id_instr", id_instr, e.instr);
                end
            end
        end
    end

`ifndef FETCH_ALIGN_CHECK_EN
    // Second instance starting at the top of the address space: first advance wraps to 0.
    initial begin
        @(posedge rst_n);
        @(posedge clk);
        #2 chk("wrap_boot_pc", pc_out_w, 32'hFFFF_FFFC);
        chk("wrap_boot_valid", 32'(id_valid_w), 32'h0);
        @(posedge clk);
        #2 chk("wrap_pc", pc_out_w, 32'h0);
        chk("wrap_pc_plus4", id_pc_plus4_w, 32'h0);
        chk("wrap_id_pc", id_pc_w, 32'hFFFF_FFFC);
        chk("wrap_valid", 32'(id_valid_w), 32'h1);
        chk("wrap_err", 32'(fetch_err_w), 32'h0);
    end
`endif

    initial begin
        logic [31:0] rpc;
        bit s, f, r;
        for (int i = 0; i < 64; i++) mem[i] = $urandom;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;

        // Boot, then 0 and 4 latched, stall three cycles at pc 8, resume.
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        repeat (3) cycle(1, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // Redirect wins over a simultaneous stall; one bubble then fetch from 0x40.
        cycle(1, 0, 1, 32'h40);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        // Flush with and without stall.
        cycle(0, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 0, 0, 0);
        // Unaligned redirect target.
        cycle(0, 0, 1, 32'h42);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);

        // Reset in the middle of a stall.
        cycle(1, 0, 0, 0);
        do_reset();
        cycle(0, 0, 0, 0);

        for (int n = 0; n < 600; n++) begin
            s = ($urandom_range(0, 3) == 0);
            f = ($urandom_range(0, 11) == 0);
            r = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 9))
                0:       rpc = 32'hFFFF_FFF8;
                1:       rpc = {24'h0, 8'($urandom_range(0, 255))};
                default: rpc = {25'h0, 5'($urandom_range(0, 31)), 2'b00};
            endcase
            cycle(s, f, r, rpc);
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
                cycle(0, 0, 0, 0);
            end
        end

        // Long straight run from reset: walks off the end of IMEM when checking is enabled.
        do_reset();
        repeat (40) cycle(0, 0, 0, 0);

        @(posedge clk);
        #3;
        chk("sb_drained", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
